// File: rtl/sa_job_sequencer.sv
// sa_job_sequencer
//
// This module collects one job of N A/B row pairs from the host. It then
// streams the rows into a systolic array on N consecutive cycles, waits for
// the array result, and holds that result until the host takes it.
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous active-low reset
//   job_valid      host offers an A/B row pair
//   job_ready      sequencer accepts a pair this cycle (IDLE/LOAD)
//   job_a_row      A row, N*DW bits
//   job_b_row      B row, N*DW bits
//   arr_valid_in   valid strobe to the array (FEED beats only)
//   arr_a          A row to the array
//   arr_b          B row to the array
//   arr_valid_out  array result valid (sampled only while waiting)
//   arr_c          array result, CW bits
//   res_valid      captured result available
//   res_ready      host consumes the result
//   res_data       captured result
//   busy           any state other than IDLE
//   err_timeout    one-cycle pulse on watchdog expiry
//   job_count      completed jobs, 16-bit wrapping
//
// Optional feature: define SA_SEQ_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT cycles. Without it, WAIT waits indefinitely and err_timeout is 0.
module sa_job_sequencer #(
    parameter int unsigned N       = 3,
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 145,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [N*DW-1:0] job_a_row,
    input  logic [N*DW-1:0] job_b_row,
    output logic            arr_valid_in,
    output logic [N*DW-1:0] arr_a,
    output logic [N*DW-1:0] arr_b,
    input  logic            arr_valid_out,
    input  logic [CW-1:0]   arr_c,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [CW-1:0]   res_data,
    output logic            busy,
    output logic            err_timeout,
    output logic [15:0]     job_count
);

    localparam int unsigned RW   = N * DW;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    // A zero TIMEOUT would make the watchdog meaningless; reject it early.
    if (TIMEOUT == 0) begin : g_timeout_check
        $error("sa_job_sequencer: TIMEOUT must be nonzero");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StFeed, StWait, StHold} state_e;

    state_e          state_q, state_d;
    // Shared counter: slot index while loading, feed index while feeding.
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RW-1:0]   a_buf_q [N];
    logic [RW-1:0]   b_buf_q [N];

    logic            arr_valid_q, arr_valid_d;
    logic [RW-1:0]   arr_a_q, arr_a_d;
    logic [RW-1:0]   arr_b_q, arr_b_d;
    logic            res_valid_q, res_valid_d;
    logic [CW-1:0]   res_data_q, res_data_d;
    logic [15:0]     job_count_q, job_count_d;

    logic            accept;
    logic            last_slot;

`ifdef SA_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0]  wd_q, wd_d;
    logic            err_q, err_d;
`endif

    assign job_ready = (state_q == StIdle) || (state_q == StLoad);
    assign busy      = (state_q != StIdle);
    assign accept    = job_valid && job_ready;
    assign last_slot = (cnt_q == CntW'(N - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arr_valid_d = 1'b0;
        arr_a_d     = '0;
        arr_b_d     = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        job_count_d = job_count_q;
`ifdef SA_SEQ_TIMEOUT_EN
        wd_d        = wd_q;
        err_d       = 1'b0;
`endif
        unique case (state_q)
            StIdle, StLoad: begin
                if (accept) begin
                    if (last_slot) begin
                        cnt_d   = '0;
                        state_d = StFeed;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = StLoad;
                    end
                end
            end
            StFeed: begin
                // Registered outputs, so the first beat appears one edge after FEED entry.
                arr_valid_d = 1'b1;
                arr_a_d     = a_buf_q[cnt_q];
                arr_b_d     = b_buf_q[cnt_q];
                if (last_slot) begin
                    cnt_d   = '0;
                    state_d = StWait;
`ifdef SA_SEQ_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                // A result arriving on the expiry cycle wins over the timeout.
                if (arr_valid_out) begin
                    res_data_d  = arr_c;
                    res_valid_d = 1'b1;
                    job_count_d = job_count_q + 16'd1;
                    state_d     = StHold;
                end
`ifdef SA_SEQ_TIMEOUT_EN
                else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
`endif
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            arr_valid_q <= 1'b0;
            arr_a_q     <= '0;
            arr_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            job_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            arr_valid_q <= arr_valid_d;
            arr_a_q     <= arr_a_d;
            arr_b_q     <= arr_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            job_count_q <= job_count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(N); i++) begin
                a_buf_q[i] <= '0;
                b_buf_q[i] <= '0;
            end
        end else if (accept) begin
            a_buf_q[cnt_q] <= job_a_row;
            b_buf_q[cnt_q] <= job_b_row;
        end
    end

`ifdef SA_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign arr_valid_in = arr_valid_q;
    assign arr_a        = arr_a_q;
    assign arr_b        = arr_b_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign job_count    = job_count_q;

endmodule

// File: tb/tb_sa_job_sequencer.sv
// Self-checking bench for sa_job_sequencer (N=3, DW=8, CW=145).
// The host driver pushes the expected array feed for each job. An array model
// pushes the expected result whenever it answers. Two monitors pop those
// queues and compare them against the DUT outputs.
module tb_sa_job_sequencer;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int RW = N * DW;
    localparam int CW = 145;
    localparam int PW = 160;

    typedef logic [RW-1:0] rows_t [N];
    typedef struct {
        logic [RW-1:0] a;
        logic [RW-1:0] b;
        int unsigned   cyc;
    } feed_t;
    typedef struct {
        logic [CW-1:0] c;
        logic [15:0]   cnt;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          job_valid, job_ready;
    logic [RW-1:0] job_a_row, job_b_row;
    logic          arr_valid_in;
    logic [RW-1:0] arr_a, arr_b;
    logic          arr_valid_out;
    logic [CW-1:0] arr_c;
    logic          res_valid, res_ready;
    logic [CW-1:0] res_data;
    logic          busy, err_timeout;
    logic [15:0]   job_count;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    feed_t feed_q[$];
    res_t  res_q[$];

    // Array model controls: 0 random latency, 1 fixed 0x1234 at 4 cycles, 2 silent
    int          arr_mode = 0;
    bit          spur_req = 0;
    bit          fire_req = 0;
    logic [15:0] completed = '0;
    int          hold_cnt = 0;

    sa_job_sequencer #(
        .N       (N),
        .DW      (DW),
        .CW      (CW),
        .TIMEOUT (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_a_row     (job_a_row),
        .job_b_row     (job_b_row),
        .arr_valid_in  (arr_valid_in),
        .arr_a         (arr_a),
        .arr_b         (arr_b),
        .arr_valid_out (arr_valid_out),
        .arr_c         (arr_c),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .job_count     (job_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] rand_c();
        logic [PW-1:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[CW-1:0];
    endfunction

    // Feed monitor
    initial begin
        feed_t f;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (arr_valid_in) begin
                    if (feed_q.size() == 0) begin
                        check("feed_unexpected", PW'(arr_valid_in), PW'(0));
                    end else begin
                        f = feed_q.pop_front();
                        check("feed_a", PW'(arr_a), PW'(f.a));
                        check("feed_b", PW'(arr_b), PW'(f.b));
                        check("feed_cycle", PW'(cyc), PW'(f.cyc));
                    end
                end else begin
                    check("idle_arr_rows", PW'({arr_a, arr_b}), PW'(0));
                    if (feed_q.size() != 0 && feed_q[0].cyc <= cyc)
                        check("feed_missing", PW'(arr_valid_in), PW'(1));
                end
`ifndef SA_SEQ_TIMEOUT_EN
                check("err_timeout_tied", PW'(err_timeout), PW'(0));
`endif
            end
        end
    end

    // Array model
    initial begin
        int            beats = 0;
        bit            pending = 0;
        int unsigned   dly = 0;
        logic [CW-1:0] pend_c;
        arr_valid_out = 1'b0;
        arr_c = '0;
        forever begin
            @(negedge clk);
            arr_valid_out = 1'b0;
            if (!reset) begin
                beats = 0;
                pending = 0;
                completed = '0;
                continue;
            end
            if (arr_valid_in) beats++;
            if (beats == N) begin
                beats = 0;
                if (arr_mode == 1) begin
                    pending = 1; dly = 3; pend_c = CW'(16'h1234);
                end else if (arr_mode == 0) begin
                    pending = 1; dly = $urandom_range(0, 6); pend_c = rand_c();
                end
            end
            if (spur_req) begin
                spur_req = 0;
                arr_valid_out = 1'b1;
                arr_c = rand_c();
            end else if (fire_req || (pending && dly == 0)) begin
                if (fire_req) pend_c = rand_c();
                fire_req = 0;
                pending = 0;
                completed = completed + 16'd1;
                arr_valid_out = 1'b1;
                arr_c = pend_c;
                res_q.push_back('{c: pend_c, cnt: completed});
            end else if (pending) begin
                dly--;
            end
        end
    end

    // Result monitor and res_ready driver
    initial begin
        res_t r;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                res_ready = 1'b0;
                continue;
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    check("res_unexpected", PW'(res_valid), PW'(0));
                end else begin
                    r = res_q[0];
                    check("res_data", PW'(res_data), PW'(r.c));
                    check("job_count", PW'(job_count), PW'(r.cnt));
                    check("hold_job_ready", PW'(job_ready), PW'(0));
                    check("hold_busy", PW'(busy), PW'(1));
                end
                if (hold_cnt > 0) begin
                    res_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    res_ready = 1'($urandom_range(0, 1));
                end
                if (res_ready && res_q.size() != 0) void'(res_q.pop_front());
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [RW-1:0] a, input logic [RW-1:0] b,
                             output int unsigned acc);
        int waited = 0;
        job_a_row = a;
        job_b_row = b;
        job_valid = 1'b1;
        while (!job_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 300) begin
                check("accept_timeout", PW'(job_ready), PW'(1));
                break;
            end
        end
        acc = cyc + 1;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic send_job(input rows_t ra, input rows_t rb, input int gap_mode,
                            output int unsigned last_acc);
        int unsigned acc = 0;
        for (int k = 0; k < N; k++) begin
            if (k > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))) begin
                job_valid = 1'b0;
                job_a_row = RW'($urandom);
                job_b_row = RW'($urandom);
                @(negedge clk);
            end
            send_beat(ra[k], rb[k], acc);
        end
        last_acc = acc;
        for (int k = 0; k < N; k++)
            feed_q.push_back('{a: ra[k], b: rb[k], cyc: acc + 1 + unsigned'(k)});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy || feed_q.size() != 0 || res_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 1000) begin
                check("idle_timeout", PW'(busy), PW'(0));
                break;
            end
        end
    endtask

    task automatic rand_rows(output rows_t ra, output rows_t rb);
        for (int k = 0; k < N; k++) begin
            ra[k] = RW'($urandom);
            rb[k] = RW'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "tb_sa_job_sequencer: global timeout");
    end

    initial begin
        rows_t       ra, rb;
        int unsigned acc;
        job_valid = 1'b0;
        job_a_row = '0;
        job_b_row = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_job_ready", PW'(job_ready), PW'(1));
        check("rst_arr_valid_in", PW'(arr_valid_in), PW'(0));
        check("rst_res_valid", PW'(res_valid), PW'(0));
        check("rst_res_data", PW'(res_data), PW'(0));
        check("rst_job_count", PW'(job_count), PW'(0));
        check("rst_err_timeout", PW'(err_timeout), PW'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed job, back-to-back, result 0x1234 four cycles into WAIT, held 5 cycles
        ra = '{24'h000741, 24'h000852, 24'h000963};
        rb = '{24'h000312, 24'h000754, 24'h000896};
        arr_mode = 1;
        hold_cnt = 5;
        send_job(ra, rb, 0, acc);
        wait_idle();
        check("job1_count", PW'(job_count), PW'(1));
        check("job1_res_data", PW'(res_data), PW'(16'h1234));

        // job_valid toggled 1,0,1,0,1
        arr_mode = 0;
        rand_rows(ra, rb);
        send_job(ra, rb, 1, acc);
        wait_idle();

        // Reset after two accepted beats
        rand_rows(ra, rb);
        send_beat(ra[0], rb[0], acc);
        send_beat(ra[1], rb[1], acc);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", PW'(busy), PW'(0));
        check("mid_rst_arr", PW'({arr_valid_in, arr_a, arr_b}), PW'(0));
        check("mid_rst_res_valid", PW'(res_valid), PW'(0));
        check("mid_rst_res_data", PW'(res_data), PW'(0));
        check("mid_rst_job_count", PW'(job_count), PW'(0));
        check("mid_rst_err", PW'(err_timeout), PW'(0));
        @(negedge clk);
        reset = 1'b1;
        // A result strobe while IDLE must be ignored
        spur_req = 1;
        repeat (3) @(negedge clk);
        check("spur_res_valid", PW'(res_valid), PW'(0));
        rand_rows(ra, rb);
        send_job(ra, rb, 0, acc);
        wait_idle();
        check("post_rst_count", PW'(job_count), PW'(1));

        // Array never answers
        arr_mode = 2;
        rand_rows(ra, rb);
        send_job(ra, rb, 0, acc);
`ifdef SA_SEQ_TIMEOUT_EN
        begin
            int unsigned err_cyc = 0;
            int          err_n = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (err_timeout) begin
                    err_n++;
                    err_cyc = cyc;
                end
            end
            check("timeout_pulses", PW'(err_n), PW'(1));
            check("timeout_cycle", PW'(err_cyc), PW'(acc + N + 32));
            check("timeout_busy", PW'(busy), PW'(0));
            check("timeout_count", PW'(job_count), PW'(completed));
        end
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("no_timeout_busy", PW'(busy), PW'(1));
        end
        fire_req = 1;
`endif
        arr_mode = 0;
        wait_idle();

        // Random jobs; the next job's beats are offered while the previous one runs
        for (int j = 0; j < 20; j++) begin
            rand_rows(ra, rb);
            send_job(ra, rb, 2, acc);
        end
        wait_idle();
        check("final_count", PW'(job_count), PW'(completed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
